// File: rtl/seq_det_session_ctrl.sv
// Session controller wrapping a serial "101" Mealy detector with hit counting.
// Latency: a completing bit sampled at edge E shows hit/match_cnt/done in the cycle after E.
// Backpressure: none; start is ignored while busy, abort cancels an active session.
module seq_det_session_ctrl #(
    parameter int CNT_W = 4,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_ovl,
    input  logic [CNT_W-1:0] target,
    input  logic [WIN_W-1:0] window,
    input  logic             data,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [WIN_W-1:0] last_pos
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ctrl_t;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        S10 = 2'd2
    } det_t;

    ctrl_t            r_state;
    det_t             r_det;
    logic             r_ovl;
    logic [CNT_W-1:0] r_target;
    logic [WIN_W-1:0] r_window;
    logic [WIN_W-1:0] r_idx;
    logic             r_busy;
    logic             r_hit;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_match_cnt;
    logic [WIN_W-1:0] r_last_pos;

    det_t             w_det_nxt;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIN_W-1:0] w_win_m1;
    logic             w_last_sample;
    logic             w_reach;

    assign w_cnt_inc     = r_match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_win_m1      = r_window - {{(WIN_W-1){1'b0}}, 1'b1};
    assign w_last_sample = (r_window != '0) && (r_idx == w_win_m1);
    assign w_reach       = w_hit && (w_cnt_inc == r_target);

    // Detector next state and hit decode for the bit on the data pin this cycle
    always_comb begin
        w_det_nxt = r_det;
        w_hit     = 1'b0;
        case (r_det)
            S0:  w_det_nxt = data ? S1 : S0;
            S1:  w_det_nxt = data ? S1 : S10;
            S10: begin
                if (data) begin
                    w_hit     = 1'b1;
                    // Overlap keeps the trailing "1" as the start of the next match
                    w_det_nxt = r_ovl ? S1 : S0;
                end else begin
                    w_det_nxt = S0;
                end
            end
            default: w_det_nxt = S0;
        endcase
    end

    // Session sequencing, counters and registered status pulses
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= IDLE;
            r_det       <= S0;
            r_ovl       <= 1'b0;
            r_target    <= '0;
            r_window    <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_match_cnt <= '0;
            r_last_pos  <= '0;
        end else begin
            r_hit     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ovl       <= mode_ovl;
                        r_target    <= target;
                        r_window    <= window;
                        r_match_cnt <= '0;
                        r_last_pos  <= '0;
                        r_idx       <= '0;
                        r_det       <= S0;
                        if (target == '0) begin
                            // Nothing to count: complete immediately without arming
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ARMED;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        // Cancel drops this edge's sample; counters keep their values
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_det <= w_det_nxt;
                        r_idx <= r_idx + {{(WIN_W-1){1'b0}}, 1'b1};
                        if (w_hit) begin
                            r_hit       <= 1'b1;
                            r_match_cnt <= w_cnt_inc;
                            r_last_pos  <= r_idx;
                        end
                        // Reaching the target takes precedence over an exhausted window
                        if (w_reach) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_last_sample) begin
                            r_timeout <= 1'b1;
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign hit       = r_hit;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign match_cnt = r_match_cnt;
    assign last_pos  = r_last_pos;

endmodule

// File: tb/tb_seq_det_session_ctrl.sv
// Bench for the 101 session controller: directed scenarios plus random traffic.
// Expected outputs come from a history-based reference of the pattern rules.
// Driver pushes per-cycle expectations; a monitor pops and compares them.
module tb_seq_det_session_ctrl;

    logic       clk = 1'b0;
    logic       arstn = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode_ovl = 1'b0;
    logic [3:0] target = '0;
    logic [7:0] window = '0;
    logic       data = 1'b0;
    logic       busy, hit, done, timeout;
    logic [3:0] match_cnt;
    logic [7:0] last_pos;

    seq_det_session_ctrl #(.CNT_W(4), .WIN_W(8)) dut (
        .clk(clk), .arstn(arstn), .start(start), .abort(abort),
        .mode_ovl(mode_ovl), .target(target), .window(window), .data(data),
        .busy(busy), .hit(hit), .done(done), .timeout(timeout),
        .match_cnt(match_cnt), .last_pos(last_pos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       hit;
        logic       done;
        logic       timeout;
        logic [3:0] cnt;
        logic [7:0] last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   n_to   = 0;
    int   n_hit  = 0;

    // Reference model state: the raw bits sampled in the current session
    bit   m_bits[$];
    bit   m_busy = 0;
    bit   m_ovl  = 0;
    int   m_tgt  = 0;
    int   m_win  = 0;
    int   m_cnt  = 0;
    int   m_last = 0;
    int   m_prev = -1000;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock of stimulus; the reference decides what the DUT shows after the edge
    task automatic cyc(input bit st, input bit ab, input bit d, input bit mo,
                       input int tg, input int wn);
        exp_t e;
        int   n;
        @(negedge clk);
        start = st; abort = ab; data = d; mode_ovl = mo;
        target = tg[3:0]; window = wn[7:0];
        e = '0;
        if (!m_busy) begin
            if (st) begin
                m_ovl = mo; m_tgt = tg; m_win = wn;
                m_cnt = 0; m_last = 0; m_prev = -1000;
                m_bits.delete();
                if (tg == 0) e.done = 1'b1;
                else m_busy = 1;
            end
        end else if (ab) begin
            m_busy = 0;
        end else begin
            n = m_bits.size();
            m_bits.push_back(d);
            // A hit is "101" ending at n; without overlap it must start after the last hit
            if (n >= 2 && m_bits[n-2] == 1 && m_bits[n-1] == 0 && d == 1 &&
                (m_ovl || (n - 2 > m_prev))) begin
                e.hit = 1'b1;
                m_prev = n;
                m_cnt++;
                m_last = n % 256;
                if (m_cnt == m_tgt) begin
                    e.done = 1'b1;
                    m_busy = 0;
                end
            end
            if (!e.done && m_win != 0 && n == m_win - 1) begin
                e.timeout = 1'b1;
                m_busy = 0;
            end
        end
        e.busy = m_busy;
        e.cnt  = m_cnt[3:0];
        e.last = m_last[7:0];
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; abort = 0; data = 0;
        arstn = 1'b0;
        #1;
        chk("reset_outputs_zero", int'({busy, hit, done, timeout, match_cnt, last_pos}), 0);
        q.delete();
        m_busy = 0; m_cnt = 0; m_last = 0; m_prev = -1000;
        m_bits.delete();
        @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every output after each active edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (hit) n_hit++;
            if (done) n_done++;
            if (timeout) n_to++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (e != {busy, hit, done, timeout, match_cnt, last_pos}) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t actual busy=%0b hit=%0b done=%0b to=%0b cnt=%0d last=%0d required busy=%0b hit=%0b done=%0b to=%0b cnt=%0d last=%0d",
                             $time, busy, hit, done, timeout, match_cnt, last_pos,
                             e.busy, e.hit, e.done, e.timeout, e.cnt, e.last);
                end
            end
        end
    end

    initial begin
        bit [6:0] pat;
        bit [4:0] pto;
        int d0, t0, h0;
        pat = 7'b1010101;
        pto = 5'b10111;

        #2 arstn = 1'b0;
        #1;
        chk("por_outputs_zero", int'({busy, hit, done, timeout, match_cnt, last_pos}), 0);
        @(negedge clk);
        arstn = 1'b1;

        // Overlapping: hits at 2,4,6 then done
        d0 = n_done; h0 = n_hit;
        cyc(1, 0, 0, 1, 3, 0);
        for (int i = 6; i >= 0; i--) cyc(0, 0, pat[i], 0, 0, 0);
        idle(2);
        chk("ovl_done_cnt", n_done - d0, 1);
        chk("ovl_hits", n_hit - h0, 3);
        chk("ovl_match_cnt", match_cnt, 3);
        chk("ovl_last_pos", last_pos, 6);

        // Non-overlapping: hits at 2 and 6
        d0 = n_done; h0 = n_hit;
        cyc(1, 0, 0, 0, 2, 0);
        for (int i = 6; i >= 0; i--) cyc(0, 0, pat[i], 0, 0, 0);
        idle(2);
        chk("novl_done_cnt", n_done - d0, 1);
        chk("novl_hits", n_hit - h0, 2);
        chk("novl_match_cnt", match_cnt, 2);
        chk("novl_last_pos", last_pos, 6);

        // Timeout with one hit
        d0 = n_done; t0 = n_to;
        cyc(1, 0, 0, 0, 2, 5);
        for (int i = 4; i >= 0; i--) cyc(0, 0, pto[i], 0, 0, 0);
        idle(2);
        chk("to_timeout_cnt", n_to - t0, 1);
        chk("to_done_cnt", n_done - d0, 0);
        chk("to_match_cnt", match_cnt, 1);
        chk("to_last_pos", last_pos, 2);

        // Done beats timeout on the same edge
        d0 = n_done; t0 = n_to;
        cyc(1, 0, 0, 1, 1, 3);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle(2);
        chk("dbt_done_cnt", n_done - d0, 1);
        chk("dbt_timeout_cnt", n_to - t0, 0);

        // Abort on the completing bit
        d0 = n_done; t0 = n_to; h0 = n_hit;
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        idle(2);
        chk("abort_pulses", (n_done - d0) + (n_to - t0) + (n_hit - h0), 0);
        chk("abort_match_cnt", match_cnt, 0);
        chk("abort_busy", busy, 0);

        // Reset mid-session, then a zero-target start
        cyc(1, 0, 0, 1, 3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        do_reset();
        d0 = n_done;
        cyc(1, 0, 0, 0, 0, 9);
        idle(2);
        chk("t0_done_cnt", n_done - d0, 1);
        chk("t0_busy", busy, 0);

        // Back-to-back: start issued in the same cycle done is high
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 2, 4);
        idle(6);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 900 == 0) begin
                do_reset();
            end else begin
                cyc(($urandom % 6) == 0, ($urandom % 50) == 0, $urandom % 2, $urandom % 2,
                    int'($urandom_range(0, 5)),
                    (($urandom % 3) == 0) ? 0 : int'($urandom_range(1, 24)));
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_session_ctrl.md
# seq_det_session_ctrl

Session controller for the serial "101" pattern detector. Software or an upstream FSM arms a detection session with a start pulse, a target hit count, an overlap mode and a sample window. The block sequences an embedded 101 Mealy detector over the serial `data` stream, counts hits, and terminates the session with either a done or a timeout indication. It sits between the serial input pin logic and the control/status register block.

## Interface
- `CNT_W`, default 4: width of the target and hit counters.
- `WIN_W`, default 8: width of the window length and sample position.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `arstn`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `start`, in, 1: one-cycle pulse; arms a session. Ignored while busy.
- `abort`, in, 1: cancels an active session.
- `mode_ovl`, in, 1: 1 selects overlapping detection, 0 selects non-overlapping. Sampled on `start`.
- `target`, in, CNT_W: number of hits that ends the session. Sampled on `start`.
- `window`, in, WIN_W: maximum number of sampled bits. 0 means unlimited. Sampled on `start`.
- `data`, in, 1: serial input; one bit per clock while busy.
- `busy`, out, 1: session active.
- `hit`, out, 1: registered pulse, one per detected 101.
- `done`, out, 1: one-cycle pulse; target reached.
- `timeout`, out, 1: one-cycle pulse; window exhausted before target reached.
- `match_cnt`, out, CNT_W: hits in the current or last session.
- `last_pos`, out, WIN_W: 0-based sample index of the most recent hit.

## Operation
- **Controller states**
  - IDLE: waits for `start`.
  - ARMED: samples `data` every edge.
- **Detector states**
  - S0: nothing matched.
  - S1: "1" seen.
  - S10: "10" seen.
- **Detector transitions**
  - S0: 1 goes to S1; 0 stays in S0.
  - S1: 0 goes to S10; 1 stays in S1.
  - S10: 0 goes to S0; 1 is a hit.
  - After a hit, the detector goes to S1 if overlap mode is set, else to S0.
- **`start` in IDLE**
  - Latch `mode_ovl`, `target` and `window`.
  - Clear `match_cnt`, `last_pos` and the sample index.
  - Set the detector to S0 and enter ARMED.
  - `data` is not sampled on the start edge.
- **`start` with target = 0**: no ARMED state. `done` pulses the next cycle with `match_cnt` = 0.
- **ARMED, each edge**
  - Sample `data` and advance the detector.
  - The sample index `idx` increments; the first sampled bit is `idx` 0.
- **On a hit**
  - `match_cnt` increments.
  - `last_pos` is set to `idx`.
  - `hit` is 1 for the following cycle.
- **End of session**
  - If `match_cnt` + 1 equals the target on a hit: `done` pulses and the controller returns to IDLE.
  - Else, if `window` ≠ 0 and `idx` = `window` − 1: `timeout` pulses and the controller returns to IDLE.
  - If both conditions hold on the same edge, `done` wins and `timeout` stays 0.
- **`abort` in ARMED**: go to IDLE at that edge. No `done`/`timeout` pulse. `match_cnt` and `last_pos` hold.
  - `abort` has priority over a simultaneous hit or termination; that hit is not counted.
  - `abort` in IDLE has no effect.
- **Counter width**: `match_cnt` cannot exceed the target, so it never wraps. `idx` never exceeds `window` − 1 when `window` ≠ 0. With unlimited window, `idx` wraps modulo 2^WIN_W.
- **Held values**: `match_cnt` and `last_pos` hold after the session ends until the next accepted `start`.

## Timing
- **Reset values**
  - Outputs: `busy`, `hit`, `done`, `timeout`, `match_cnt`, `last_pos` are all 0.
  - Internal state: controller IDLE, detector S0.
- **Reset mid-session**: immediately returns to IDLE with all outputs 0. No pulse is emitted.
- All outputs are registered.
- `busy` is 1 from the cycle after the `start` edge. It falls in the same cycle that `done` or `timeout` is high.
- **Latency**: a completing "1" sampled at edge E gives `hit`, the updated `match_cnt` and, if terminal, `done`, all high in the cycle after E.
- **Back-to-back sessions**: `start` is accepted in the cycle `done`/`timeout` is high, because the controller is already IDLE.

## Test plan
- **Overlapping hits**: overlap mode, target 3, window 0, data 1,0,1,0,1,0,1.
  - `hit` at idx 2, 4 and 6.
  - `done` after idx 6 with `match_cnt` = 3 and `last_pos` = 6.
- **Non-overlapping hits**: non-overlap mode, target 2, window 0, same stream.
  - Hits at idx 2 and 6 only.
  - `done` with `match_cnt` = 2 and `last_pos` = 6.
- **Timeout**: target 2, window 5, data 1,0,1,1,1.
  - `timeout` after idx 4 with `match_cnt` = 1 and `last_pos` = 2. `done` stays 0.
- **Done beats timeout**: target 1, window 3, data 1,0,1.
  - `done` = 1 and `timeout` = 0 after idx 2.
- **Abort**: `abort` asserted on the edge sampling idx 2 of 1,0,1.
  - Controller returns to IDLE with no pulse, `match_cnt` = 0 and no `hit`.
- **Reset mid-session and target 0**
  - `arstn` low mid-session: all outputs 0 immediately.
  - After release, `start` with target 0: `done` pulses the next cycle and `busy` stays 0.
